mc_ctrl_fsm: RTL



---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/mc_alu_dec.sv | 45 ++++
 rtl/mc_ctrl_fsm.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control unit:
// state codes, opcodes, ALU op encoding, select codes, decode helpers.
package ctrl_pkg;

  localparam logic [3:0] S_IF   = 4'd0;
  localparam logic [3:0] S_ID   = 4'd1;
  localparam logic [3:0] S_EX   = 4'd2;
  localparam logic [3:0] S_MEM  = 4'd3;
  localparam logic [3:0] S_WB   = 4'd4;
  localparam logic [3:0] S_HALT = 4'd15;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // flags = {Z,N,C,V}; C is the borrow of lhs-rhs
  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic [3:0] flags
  );
    logic z, n, c, v;
    {z, n, c, v} = flags;
    case (f3)
      3'd0:    br_taken = z;
      3'd1:    br_taken = !z;
      3'd4:    br_taken = n ^ v;
      3'd5:    br_taken = !(n ^ v);
      3'd6:    br_taken = c;
      3'd7:    br_taken = !c;
      default: br_taken = 1'b0;
    endcase
  endfunction

  function automatic logic op_known(input logic [6:0] op);
    op_known = op inside {
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    };
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode from opcode/funct3/funct7_5.
// Branches subtract; non-ALU opcodes add (address/pc arithmetic).
module mc_alu_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  logic is_op;
  logic is_alu;
  logic is_br;
  logic sub_en;

  assign is_op  = opcode == OP_OP;
  assign is_alu = is_op || (opcode == OP_IMM);
  assign is_br  = opcode == OP_BRANCH;
  // ADDI has no SUB form; funct7_5 only selects SUB on R-type
  assign sub_en = is_op && funct7_5;

  // funct3 table for R/I ALU ops, SUB for compare, ADD otherwise
  always_comb begin
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_br: alu_op = ALU_SUB;
      is_alu: begin
        case (funct3)
          3'd0: alu_op = sub_en ? ALU_SUB : ALU_ADD;
          3'd1: alu_op = ALU_SLL;
          3'd2: alu_op = ALU_SLT;
          3'd3: alu_op = ALU_SLTU;
          3'd4: alu_op = ALU_XOR;
          3'd5: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'd6: alu_op = ALU_OR;
          3'd7: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: IF/ID/EX/MEM/WB sequencing and strobes.
// Optional CTRL_MEM_WAIT_EN adds dm_ready to stretch the MEM state.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [3:0]  alu_flags,
`ifdef CTRL_MEM_WAIT_EN
  input  logic        dm_ready,
`endif
  output logic [3:0]  stat,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_update_sel,
  output logic [31:0] pc_reset_val,
  output logic        rf_write,
  output logic        dm_write,
  output logic        mdr_write,
  output logic        lhs_sel,
  output logic        rhs_sel,
  output logic [3:0]  alu_op,
  output logic [1:0]  wb_data_sel,
  output logic        halted
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       mem_done;
  logic       legal;
  logic       is_op, is_load, is_store, is_br;
  logic       is_jal, is_jalr, is_lui, is_auipc;
  logic       in_if, in_ex, in_mem, in_wb, in_halt;
  logic [3:0] dec_alu_op;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_done = dm_ready;
`else
  assign mem_done = 1'b1;
`endif

  assign is_op    = opcode == OP_OP;
  assign is_load  = opcode == OP_LOAD;
  assign is_store = opcode == OP_STORE;
  assign is_br    = opcode == OP_BRANCH;
  assign is_jal   = opcode == OP_JAL;
  assign is_jalr  = opcode == OP_JALR;
  assign is_lui   = opcode == OP_LUI;
  assign is_auipc = opcode == OP_AUIPC;

  assign legal = op_known(opcode)
              && !(is_br && funct3[2:1] == 2'b01);

  // State register; reset restarts fetch
  always_ff @(posedge clk) begin
    if (rst) state <= S_IF;
    else     state <= state_nxt;
  end

  // Next-state sequencing per instruction class
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IF:   state_nxt = S_ID;
      S_ID:   state_nxt = legal ? S_EX : S_HALT;
      S_EX: begin
        if (is_br)                     state_nxt = S_IF;
        else if (is_load || is_store)  state_nxt = S_MEM;
        else                           state_nxt = S_WB;
      end
      S_MEM: begin
        if (!mem_done)    state_nxt = S_MEM;
        else if (is_load) state_nxt = S_WB;
        else              state_nxt = S_IF;
      end
      S_WB:   state_nxt = S_IF;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Reset masks every state-qualified strobe combinationally
  assign in_if   = !rst && state == S_IF;
  assign in_ex   = !rst && state == S_EX;
  assign in_mem  = !rst && state == S_MEM;
  assign in_wb   = !rst && state == S_WB;
  assign in_halt = !rst && state == S_HALT;

  assign stat      = rst ? S_IF : state;
  assign ir_write  = in_if;
  assign rf_write  = in_wb;
  assign dm_write  = in_mem && is_store;
  assign mdr_write = in_mem && is_load;
  assign halted    = in_halt;
  assign pc_write  = in_wb
                  || (in_mem && is_store && mem_done)
                  || (in_ex && is_br);

  assign pc_reset_val = RESET_PC;

  mc_alu_dec u_alu_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (dec_alu_op)
  );

  assign alu_op  = rst ? ALU_ADD : dec_alu_op;
  assign lhs_sel = !rst && is_auipc;
  assign rhs_sel = !rst && !(is_op || is_br);

  // PC source: branch target, jump target, or sequential
  always_comb begin
    pc_update_sel = PC_PLUS4;
    if (!rst) begin
      unique case (1'b1)
        is_br:   pc_update_sel = br_taken(funct3, alu_flags)
                               ? PC_IMM : PC_PLUS4;
        is_jal:  pc_update_sel = PC_IMM;
        is_jalr: pc_update_sel = PC_ALU;
        default: pc_update_sel = PC_PLUS4;
      endcase
    end
  end

  // Write-back source by instruction class
  always_comb begin
    wb_data_sel = WB_ALU;
    if (!rst) begin
      unique case (1'b1)
        is_load:          wb_data_sel = WB_MDR;
        is_jal || is_jalr: wb_data_sel = WB_PC4;
        is_lui:           wb_data_sel = WB_IMM;
        default:          wb_data_sel = WB_ALU;
      endcase
    end
  end

endmodule
